// File: rtl/nios_mul_pkg.sv
// Shared types and latency constants for the sequential Nios II multiplier.
package nios_mul_pkg;

   typedef enum logic [1:0] {
      MUL_LO  = 2'd0,
      MULX_UU = 2'd1,
      MULX_SU = 2'd2,
      MULX_SS = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      StIdle,
      StP0,
      StP1,
      StP2,
      StP3,
      StDrain,
      StFix,
      StDone
   } state_e;

   localparam int unsigned LatMul      = 4;
   localparam int unsigned LatMulxUu   = 5;
   localparam int unsigned LatMulxSgn  = 6;
   localparam int unsigned LatZeroSkip = 2;

   // Cycles from the accepting edge to out_valid.
   function automatic int unsigned op_latency(input op_e op, input logic zero_skip);
      if (zero_skip) return LatZeroSkip;
      case (op)
         MUL_LO:  return LatMul;
         MULX_UU: return LatMulxUu;
         default: return LatMulxSgn;
      endcase
   endfunction

endpackage

// File: rtl/mul16_cell.sv
// Registered HALF_W x HALF_W unsigned multiplier, one cycle latency.
module mul16_cell #(
   parameter int unsigned HALF_W = 16
) (
   input  logic                  i_clk,
   input  logic                  i_aclr,
   input  logic                  i_en,
   input  logic [HALF_W-1:0]     i_a,
   input  logic [HALF_W-1:0]     i_b,
   output logic [2*HALF_W-1:0]   o_p
);

   logic [2*HALF_W-1:0] r_p;

   always_ff @(posedge i_clk or posedge i_aclr) begin
      if (i_aclr) begin
         r_p <= '0;
      end else if (i_en) begin
         r_p <= {{HALF_W{1'b0}}, i_a} * {{HALF_W{1'b0}}, i_b};
      end
   end

   assign o_p = r_p;

endmodule

// File: rtl/nios_mul_seq.sv
// Multicycle MUL/MULXUU/MULXSU/MULXSS unit built around one registered 16x16 cell.
// Optional NIOS_MUL_SEQ_ZERO_SKIP_EN: zero operands short-circuit to DONE.
module nios_mul_seq
   import nios_mul_pkg::*;
#(
   parameter int unsigned HALF_W = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_op,
   input  logic [2*HALF_W-1:0]   in_a,
   input  logic [2*HALF_W-1:0]   in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*HALF_W-1:0]   out_result,
   output logic                  busy
);

   localparam int unsigned OpW  = 2 * HALF_W;
   localparam int unsigned AccW = 4 * HALF_W;

   if (HALF_W != 16) begin : g_bad_half_w
      $error("nios_mul_seq: only HALF_W=16 is supported");
   end

   state_e              r_state, w_state_d;
   op_e                 r_op;
   logic [OpW-1:0]      r_a, r_b;
   logic [AccW-1:0]     r_acc, w_acc_d, w_addend;
   logic                r_pend_vld, w_issue;
   logic [1:0]          r_pend_sh, w_sh_d;
   logic                w_a_hi, w_b_hi, w_cell_en, w_aclr, w_accept;
   logic [HALF_W-1:0]   w_cell_a, w_cell_b;
   logic [OpW-1:0]      w_cell_p;

`ifdef NIOS_MUL_SEQ_ZERO_SKIP_EN
   logic w_zero;
   assign w_zero = (r_a == '0) || (r_b == '0);
`endif

   assign w_accept  = (r_state == StIdle) && in_valid;
   assign w_cell_en = (r_state inside {StP0, StP1, StP2, StP3, StDrain});
   assign w_aclr    = ~reset_n;
   assign w_cell_a  = w_a_hi ? r_a[OpW-1:HALF_W] : r_a[HALF_W-1:0];
   assign w_cell_b  = w_b_hi ? r_b[OpW-1:HALF_W] : r_b[HALF_W-1:0];

   mul16_cell #(
      .HALF_W (HALF_W)
   ) u_cell (
      .i_clk  (clk),
      .i_aclr (w_aclr),
      .i_en   (w_cell_en),
      .i_a    (w_cell_a),
      .i_b    (w_cell_b),
      .o_p    (w_cell_p)
   );

   // Partial issued last cycle, placed at its shift.
   always_comb begin
      w_addend = '0;
      case (r_pend_sh)
         2'd0:    w_addend = {{OpW{1'b0}}, w_cell_p};
         2'd1:    w_addend = {{HALF_W{1'b0}}, w_cell_p, {HALF_W{1'b0}}};
         default: w_addend = {w_cell_p, {OpW{1'b0}}};
      endcase
   end

   always_comb begin
      w_state_d = r_state;
      w_acc_d   = r_acc;
      w_issue   = 1'b0;
      w_a_hi    = 1'b0;
      w_b_hi    = 1'b0;
      w_sh_d    = 2'd0;
      if (r_pend_vld) w_acc_d = r_acc + w_addend;
      case (r_state)
         StIdle: begin
            if (in_valid) begin
               w_state_d = StP0;
               w_acc_d   = '0;
            end
         end
         StP0: begin
            w_issue   = 1'b1;
            w_state_d = StP1;
         end
         StP1: begin
            w_issue   = 1'b1;
            w_b_hi    = 1'b1;
            w_sh_d    = 2'd1;
            w_state_d = StP2;
`ifdef NIOS_MUL_SEQ_ZERO_SKIP_EN
            if (w_zero) begin
               w_issue   = 1'b0;
               w_state_d = StDone;
            end
`endif
         end
         StP2: begin
            w_issue   = 1'b1;
            w_a_hi    = 1'b1;
            w_sh_d    = 2'd1;
            w_state_d = (r_op == MUL_LO) ? StDrain : StP3;
         end
         StP3: begin
            w_issue   = 1'b1;
            w_a_hi    = 1'b1;
            w_b_hi    = 1'b1;
            w_sh_d    = 2'd2;
            w_state_d = StDrain;
         end
         StDrain: begin
            w_state_d = (r_op == MULX_SU || r_op == MULX_SS) ? StFix : StDone;
         end
         StFix: begin
            // Convert the unsigned high word to the signed-operand product.
            w_acc_d[AccW-1:OpW] = r_acc[AccW-1:OpW]
                                - (r_a[OpW-1] ? r_b : '0)
                                - ((r_op == MULX_SS && r_b[OpW-1]) ? r_a : '0);
            w_state_d = StDone;
         end
         StDone: begin
            if (out_ready) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= StIdle;
         r_op       <= MUL_LO;
         r_a        <= '0;
         r_b        <= '0;
         r_acc      <= '0;
         r_pend_vld <= 1'b0;
         r_pend_sh  <= 2'd0;
      end else begin
         r_state    <= w_state_d;
         r_acc      <= w_acc_d;
         r_pend_vld <= w_issue;
         r_pend_sh  <= w_sh_d;
         if (w_accept) begin
            r_op <= op_e'(in_op);
            r_a  <= in_a;
            r_b  <= in_b;
         end
      end
   end

   assign in_ready  = (r_state == StIdle);
   assign busy      = (r_state != StIdle);
   assign out_valid = (r_state == StDone);

   always_comb begin
      out_result = '0;
      if (r_state == StDone) begin
         out_result = (r_op == MUL_LO) ? r_acc[OpW-1:0] : r_acc[AccW-1:OpW];
      end
   end

endmodule

// File: doc/nios_mul_seq.md
Name: nios_mul_seq

Overview:
- Sequential consumer of 16x16 unsigned partial products; produces the 32-bit Nios II multiply results MUL, MULXUU, MULXSU and MULXSS.
- Reuses a single registered 16x16 cell over several cycles, accumulating into a 64-bit register.
- Sits beside the CPU execute stage as a multicycle functional unit, with a valid/ready request in and a valid/ready result out.
- Serves as the low-area alternative to the three-cell parallel partial-product array.

Parameters:
- HALF_W, 16: half operand width; operands are 2*HALF_W. Only 16 is supported; any other value is rejected at elaboration.

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous reset, active low
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_op  in  2  0=MUL, 1=MULXUU, 2=MULXSU (a signed, b unsigned), 3=MULXSS
- in_a  in  32  operand A
- in_b  in  32  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  32  MUL gives product[31:0]; MULX* gives product[63:32]
- busy  out  1  high in any state other than IDLE

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values: in_ready=1, out_valid=0, out_result=0, busy=0; FSM=IDLE; accumulator and operand registers cleared.
- Accept: a request is accepted on an edge where in_valid&&in_ready. in_ready=1 only in IDLE. Operands and op are latched on acceptance.
- FSM: IDLE -> P0 -> P1 -> P2 -> [P3] -> [FIX] -> DONE -> IDLE.
- Cell schedule: P0 issues aL*bL, P1 issues aL*bH, P2 issues aH*bL, P3 issues aH*bH. The cell output is registered, so each partial is accumulated one cycle after it is issued.
- Accumulation shifts: p0 at shift 0, p1 and p2 at shift 16, p3 at shift 32. The accumulator is 64 bits and wraps modulo 2^64.
- MUL skips P3 and FIX; a drain cycle accumulates p2 before DONE.
- MULXUU skips FIX.
- FIX state (MULXSU, MULXSS), applied to acc[63:32]:
  - subtract b if a[31]=1;
  - for MULXSS only, also subtract a if b[31]=1.
- Latency from the accepting edge to out_valid=1: MUL 4 cycles, MULXUU 5, MULXSU/MULXSS 6.
- DONE: out_valid=1 and out_result is stable until an edge with out_ready=1, then the FSM returns to IDLE. No new request is accepted in the same cycle (one-cycle bubble).
- in_valid while busy: ignored; the requester holds it, since in_ready=0.
- Operand changes after acceptance have no effect.
- Reset mid-operation: outputs return to their reset values immediately (asynchronous). The in-flight result is discarded, and the first accept after reset release behaves normally.
- The cell enable is high only while in P0..P3 or the drain cycle. The cell clear is tied to ~reset_n.

Optional Feature:
- Macro: NIOS_MUL_SEQ_ZERO_SKIP_EN.
- Defined: if latched a==0 or b==0, the FSM goes directly to DONE with the accumulator at 0. out_valid is asserted 2 cycles after acceptance for every op.
- Undefined: zero operands take the normal full latency.
- The result value is identical in both builds.

Decomposition:
- Shared package nios_mul_pkg:
  - op enum: MUL_LO, MULX_UU, MULX_SU, MULX_SS;
  - FSM state enum;
  - localparams for the per-op latencies (4/5/6, and 2 for zero-skip).
- Sub-module mul16_cell: registered 16x16 unsigned multiplier with en and aclr, 1-cycle latency.
- The top holds the FSM, operand registers, accumulator and sign fix.

Test Plan:
- MUL a=0x00010002, b=0x00030004, out_ready=1 -> out_result=0x000A0008, out_valid exactly 4 cycles after accept.
- MULXUU a=b=0xFFFFFFFF -> 0xFFFFFFFE after 5 cycles; MULXSS a=b=0xFFFFFFFF -> 0x00000000 after 6 cycles.
- MULXSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; MULXSS a=0x80000000, b=0x7FFFFFFF -> 0xC0000000.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_result held constant, in_ready=0. Then out_ready=1 -> IDLE and in_ready=1 on the next cycle; a back-to-back request is accepted only after the bubble.
- Reset mid-op: assert reset_n=0 in P2 -> out_valid=0, in_ready=1, busy=0 immediately. A new MUL 7*6 then gives 42 after 4 cycles.
- Zero operand a=0, b=0x12345678 MULXUU -> result 0; latency 2 cycles with NIOS_MUL_SEQ_ZERO_SKIP_EN defined, 5 cycles without it.
